// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// Owner encodings and the FSM state enum live here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    localparam logic ARB_SRC_IF = 1'b0;
    localparam logic ARB_SRC_DM = 1'b1;

    function automatic arb_state_t busy_state(input logic src);
        return (src == ARB_SRC_DM) ? BUSY_DM : BUSY_IF;
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of consecutive data grants made while fetch waits.
// Clear has priority over increment.
module starve_counter #(
    parameter  int MAX = 4,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic         o_sat,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_sat;

    assign w_sat   = (r_count == W'(MAX));
    assign o_sat   = w_sat;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_sat) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the memory port shared by fetch and load/store.
// Data wins unless fetch has waited through MAX_DATA_BURST data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_valid,
    output logic                    if_stall,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_valid,
    output logic                    dm_stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MAX_DATA_BURST + 1);

    arb_state_t            r_state;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [SW-1:0]         r_mem_wstrb;

    logic          w_idle;
    logic          w_sat;
    logic          w_grant_if;
    logic          w_grant_dm;
    logic          w_src;
    logic          w_inc;
    logic          w_clr;
    logic [CW-1:0] w_count;

    // Only IDLE samples requests, so the ack cycle never re-grants.
    assign w_idle     = (r_state == IDLE);
    assign w_grant_if = w_idle & if_req & (~dm_req | w_sat);
    assign w_grant_dm = w_idle & dm_req & ~w_grant_if;
    assign w_src      = w_grant_dm ? ARB_SRC_DM : ARB_SRC_IF;
    assign w_inc      = w_grant_dm & if_req;
    assign w_clr      = w_grant_if | (w_grant_dm & ~if_req);

    starve_counter #(
        .MAX (MAX_DATA_BURST)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_inc),
        .i_clr   (w_clr),
        .o_sat   (w_sat),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_count <= CW'(MAX_DATA_BURST));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_if || w_grant_dm) begin
                        r_state     <= busy_state(w_src);
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_grant_dm & dm_we;
                        r_mem_addr  <= w_grant_dm ? dm_addr : if_addr;
                        r_mem_wdata <= w_grant_dm ? dm_wdata : '0;
                        r_mem_wstrb <= w_grant_dm ? dm_wstrb : '0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign if_valid = (r_state == BUSY_IF) & mem_ack;
    assign dm_valid = (r_state == BUSY_DM) & mem_ack;
    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus
// hand sequences for starvation, streak clear and reset mid-access.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MAX_DATA_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wstrb  (dm_wstrb),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .dm_stall  (dm_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dstrb;
        logic        ack;
        logic [31:0] rdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic [3:0]  e_mstrb;
        logic        e_iv;
        logic        e_dv;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic dwe,
        input logic [31:0] daddr, input logic [31:0] dwdata,
        input logic [3:0] dstrb,
        input logic ack, input logic [31:0] rdata,
        input logic e_mreq, input logic e_mwe,
        input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
        input logic [3:0] e_mstrb,
        input logic e_iv, input logic e_dv);
        vec_t v;
        v.ireq = ireq;     v.iaddr = iaddr;
        v.dreq = dreq;     v.dwe = dwe;
        v.daddr = daddr;   v.dwdata = dwdata;
        v.dstrb = dstrb;   v.ack = ack;
        v.rdata = rdata;   v.e_mreq = e_mreq;
        v.e_mwe = e_mwe;   v.e_maddr = e_maddr;
        v.e_mwdata = e_mwdata;
        v.e_mstrb = e_mstrb;
        v.e_iv = e_iv;     v.e_dv = e_dv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0;
        dm_wdata = 0; dm_wstrb = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    localparam bit [9:0] STARVE_ORDER = 10'b1111011110;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        // reset / fetch only
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,
                        0,0,0,0,0,0,0));
        vq.push_back(mk(1,32'h100,0,0,0,0,0,0,0,
                        0,0,0,0,0,0,0));
        vq.push_back(mk(1,32'h100,0,0,0,0,0,0,0,
                        1,0,32'h100,0,0,0,0));
        vq.push_back(mk(1,32'h100,0,0,0,0,0,1,32'hDEADBEEF,
                        1,0,32'h100,0,0,1,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,
                        0,0,32'h100,0,0,0,0));
        // conflict: data first, then fetch
        vq.push_back(mk(1,32'h104,1,0,32'h2000,0,0,0,0,
                        0,0,32'h100,0,0,0,0));
        vq.push_back(mk(1,32'h104,1,0,32'h2000,0,0,1,32'hA5A50001,
                        1,0,32'h2000,0,0,0,1));
        vq.push_back(mk(1,32'h104,0,0,0,0,0,0,0,
                        0,0,32'h2000,0,0,0,0));
        vq.push_back(mk(1,32'h104,0,0,0,0,0,1,32'h13,
                        1,0,32'h104,0,0,1,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,
                        0,0,32'h104,0,0,0,0));
        // ack while idle is ignored
        vq.push_back(mk(0,0,0,0,0,0,0,1,32'hFFFF0000,
                        0,0,32'h104,0,0,0,0));
        // store
        vq.push_back(mk(0,0,1,1,32'h40,32'h12345678,4'b0011,0,0,
                        0,0,32'h104,0,0,0,0));
        vq.push_back(mk(0,0,1,1,32'h40,32'h12345678,4'b0011,0,0,
                        1,1,32'h40,32'h12345678,4'b0011,0,0));
        vq.push_back(mk(0,0,1,1,32'h40,32'h12345678,4'b0011,1,0,
                        1,1,32'h40,32'h12345678,4'b0011,0,1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,
                        0,1,32'h40,32'h12345678,4'b0011,0,0));
        // load withdrawn after grant
        vq.push_back(mk(0,0,1,0,32'h300,0,0,0,0,
                        0,1,32'h40,32'h12345678,4'b0011,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,
                        1,0,32'h300,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,
                        1,0,32'h300,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,1,32'h77,
                        1,0,32'h300,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,
                        0,0,32'h300,0,0,0,0));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vq[i]) begin
            if_req    = vq[i].ireq;
            if_addr   = vq[i].iaddr;
            dm_req    = vq[i].dreq;
            dm_we     = vq[i].dwe;
            dm_addr   = vq[i].daddr;
            dm_wdata  = vq[i].dwdata;
            dm_wstrb  = vq[i].dstrb;
            mem_ack   = vq[i].ack;
            mem_rdata = vq[i].rdata;
            #2;
            chk($sformatf("row%0d mem_req", i),
                32'(mem_req), 32'(vq[i].e_mreq));
            chk($sformatf("row%0d mem_we", i),
                32'(mem_we), 32'(vq[i].e_mwe));
            chk($sformatf("row%0d mem_addr", i),
                mem_addr, vq[i].e_maddr);
            chk($sformatf("row%0d mem_wdata", i),
                mem_wdata, vq[i].e_mwdata);
            chk($sformatf("row%0d mem_wstrb", i),
                32'(mem_wstrb), 32'(vq[i].e_mstrb));
            chk($sformatf("row%0d if_valid", i),
                32'(if_valid), 32'(vq[i].e_iv));
            chk($sformatf("row%0d dm_valid", i),
                32'(dm_valid), 32'(vq[i].e_dv));
            chk($sformatf("row%0d if_stall", i), 32'(if_stall),
                32'(vq[i].ireq & ~vq[i].e_iv));
            chk($sformatf("row%0d dm_stall", i), 32'(dm_stall),
                32'(vq[i].dreq & ~vq[i].e_dv));
            if (vq[i].e_iv)
                chk($sformatf("row%0d if_rdata", i),
                    if_rdata, vq[i].rdata);
            if (vq[i].e_dv)
                chk($sformatf("row%0d dm_rdata", i),
                    dm_rdata, vq[i].rdata);
            next_cyc();
        end

        // starvation guard: both held, immediate acks
        idle_inputs();
        if_req = 1; if_addr = 32'h1000;
        dm_req = 1; dm_addr = 32'h2000;
        for (int g = 0; g < 10; g++) begin
            logic e;
            e = STARVE_ORDER[9-g];
            mem_ack = 0;
            #2;
            chk($sformatf("starve%0d idle mem_req", g),
                32'(mem_req), 32'd0);
            next_cyc();
            mem_ack = 1;
            mem_rdata = 32'(g);
            #2;
            chk($sformatf("starve%0d grant", g),
                32'({if_valid, dm_valid}), 32'({~e, e}));
            chk($sformatf("starve%0d addr", g), mem_addr,
                e ? 32'h2000 : 32'h1000);
            next_cyc();
        end

        // two data grants with fetch waiting, then fetch withdraws
        mem_ack = 0;
        for (int g = 0; g < 2; g++) begin
            mem_ack = 0;
            next_cyc();
            mem_ack = 1;
            #2;
            chk($sformatf("streak%0d dm_valid", g),
                32'(dm_valid), 32'd1);
            next_cyc();
        end
        mem_ack = 0;
        if_req = 0;
        dm_we = 1; dm_addr = 32'h40;
        dm_wdata = 32'h12345678; dm_wstrb = 4'b0011;
        #2;
        chk("streak before store",
            32'(dut.u_starve.o_count), 32'd2);
        next_cyc();
        mem_ack = 1;
        #2;
        chk("store2 mem_we", 32'(mem_we), 32'd1);
        chk("store2 mem_wstrb", 32'(mem_wstrb), 32'h3);
        chk("store2 dm_valid", 32'(dm_valid), 32'd1);
        next_cyc();
        idle_inputs();
        #2;
        chk("streak after store",
            32'(dut.u_starve.o_count), 32'd0);
        chk("store2 one pulse", 32'(dm_valid), 32'd0);
        next_cyc();

        // reset while a fetch is outstanding
        if_req = 1; if_addr = 32'h500;
        next_cyc();
        #2;
        chk("rstmid busy mem_req", 32'(mem_req), 32'd1);
        rst = 1;
        next_cyc();
        rst = 0;
        if_req = 0;
        mem_ack = 1; mem_rdata = 32'hBADBAD00;
        #2;
        chk("rstmid state",
            32'(dut.r_state), 32'(IDLE));
        chk("rstmid mem_req", 32'(mem_req), 32'd0);
        chk("rstmid mem_addr", mem_addr, 32'd0);
        chk("rstmid if_valid", 32'(if_valid), 32'd0);
        chk("rstmid dm_valid", 32'(dm_valid), 32'd0);
        next_cyc();
        mem_ack = 0;
        #2;
        chk("post ack state",
            32'(dut.r_state), 32'(IDLE));
        chk("post ack mem_req", 32'(mem_req), 32'd0);
        next_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
